// File: rtl/idu_stage_if.sv
// idu_stage_if: decoded-packet bus from the decode stage to EXU/LSU.
// The master side drives the packet; the slave side returns out_ready.
interface idu_stage_if #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN / 8
);
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic              wen;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [11:0]       csr_addr;
    logic [XLEN-1:0]   imm;
    logic [4:0]        op;
    logic              mem_valid;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_addr;
    logic [1:0]        mem_size;
    logic              mem_signed;
    logic [MASK_W-1:0] mem_wmask;
    logic              misalign;
    logic              is_ebreak;
    logic              illegal_instruction;

    modport master(
        output out_valid, out_pc, wen, rs1_addr, rs2_addr, rd_addr, csr_addr, imm, op,
               mem_valid, mem_wen, mem_addr, mem_size, mem_signed, mem_wmask, misalign,
               is_ebreak, illegal_instruction,
        input  out_ready
    );
    modport slave(
        input  out_valid, out_pc, wen, rs1_addr, rs2_addr, rd_addr, csr_addr, imm, op,
               mem_valid, mem_wen, mem_addr, mem_size, mem_signed, mem_wmask, misalign,
               is_ebreak, illegal_instruction,
        output out_ready
    );
endinterface

// File: rtl/idu_stage.sv
// idu_stage: registered RV32I-subset decode stage between IFU and EXU/LSU with sticky halt.
// Defining IDU_PERF_CNT_EN adds saturating instruction/illegal perf counters.
module idu_stage #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN / 8,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    output logic [4:0]       rs1_raddr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic             flush,
`ifdef IDU_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_inst_cnt,
    output logic [CNT_W-1:0] perf_illegal_cnt,
`endif
    idu_stage_if.master      exu
);
    localparam logic [4:0] OP_ADD = 5'd0, OP_ADDI = 5'd1, OP_LUI = 5'd2, OP_AUIPC = 5'd3,
                           OP_JAL = 5'd4, OP_JALR = 5'd5, OP_LOAD = 5'd6, OP_STORE = 5'd7,
                           OP_CSRRW = 5'd8, OP_EBREAK = 5'd9, OP_ILLEGAL = 5'd31;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("idu_stage: XLEN must be 32 or 64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("idu_stage: CNT_W must be positive");
    end

    typedef enum logic {RUN, HALT} state_t;
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              wen;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [11:0]       csr;
        logic [XLEN-1:0]   imm;
        logic [4:0]        op;
        logic              mem_valid;
        logic              mem_wen;
        logic [XLEN-1:0]   mem_addr;
        logic [1:0]        mem_size;
        logic              mem_signed;
        logic [MASK_W-1:0] wmask;
        logic              misalign;
        logic              ebreak;
        logic              illegal;
    } pkt_t;

    state_t          state, state_nx;
    pkt_t            d, q;
    logic            valid_q, acc, take;
    logic [6:0]      opc;
    logic [2:0]      f3, off, aoff;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;

    assign rs1_raddr = inst[19:15];
    assign acc       = in_valid && in_ready && !flush;
    assign take      = acc && inst != 32'd0;

    always_comb begin
        opc   = inst[6:0];
        f3    = inst[14:12];
        imm_i = XLEN'($signed(inst[31:20]));
        imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
        imm_u = XLEN'($signed({inst[31:12], 12'h000}));
        imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        d     = '0;
        d.pc  = pc;
        d.rs1 = inst[19:15];
        d.rs2 = inst[24:20];
        d.rd  = inst[11:7];
        d.csr = inst[31:20];
        d.op  = (opc == 7'h33 && f3 == 3'd0 && inst[31:25] == 7'd0) ? OP_ADD :
                (opc == 7'h13 && f3 == 3'd0) ? OP_ADDI :
                (opc == 7'h37) ? OP_LUI :
                (opc == 7'h17) ? OP_AUIPC :
                (opc == 7'h6f) ? OP_JAL :
                (opc == 7'h67 && f3 == 3'd0) ? OP_JALR :
                (opc == 7'h03 && f3 != 3'd3 && f3[2:1] != 2'b11) ? OP_LOAD :
                (opc == 7'h23 && !f3[2] && f3[1:0] != 2'b11) ? OP_STORE :
                (opc == 7'h73 && f3 == 3'd1) ? OP_CSRRW :
                (inst == 32'h0010_0073) ? OP_EBREAK : OP_ILLEGAL;
        d.imm = (d.op == OP_ADDI || d.op == OP_JALR || d.op == OP_LOAD) ? imm_i :
                (d.op == OP_STORE) ? imm_s :
                (d.op == OP_LUI || d.op == OP_AUIPC) ? imm_u :
                (d.op == OP_JAL) ? imm_j : '0;
        d.illegal    = d.op == OP_ILLEGAL && inst != 32'd0;
        d.ebreak     = d.op == OP_EBREAK || d.illegal;
        d.wen        = d.rd != 5'd0 && d.op != OP_STORE && !d.ebreak;
        d.mem_valid  = d.op == OP_LOAD || d.op == OP_STORE;
        d.mem_wen    = d.op == OP_STORE;
        d.mem_addr   = rs1_data + d.imm;
        d.mem_size   = d.mem_valid ? f3[1:0] : 2'd0;
        d.mem_signed = d.op == OP_LOAD && !f3[2];
        // Byte lane within the bus word; 64-bit buses use one extra address bit.
        off          = XLEN == 64 ? d.mem_addr[2:0] : {1'b0, d.mem_addr[1:0]};
        aoff         = d.mem_size == 2'd2 ? {off[2], 2'b00} :
                       d.mem_size == 2'd1 ? {off[2:1], 1'b0} : off;
        d.wmask      = d.mem_wen ? MASK_W'(d.mem_size == 2'd2 ? 4'hf :
                                           d.mem_size == 2'd1 ? 4'h3 : 4'h1) << aoff : '0;
        d.misalign   = (d.mem_size == 2'd1 && off[0]) || (d.mem_size == 2'd2 && off[1:0] != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            q       <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (take) begin
            valid_q <= 1'b1;
            q       <= d;
        end else if (acc || exu.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nx;
    end

    always_comb state_nx = (state == RUN && take && d.ebreak) ? HALT : state;

    always_comb in_ready = state == RUN && (!valid_q || exu.out_ready);

    assign exu.out_valid           = valid_q;
    assign exu.out_pc              = q.pc;
    assign exu.wen                 = q.wen;
    assign exu.rs1_addr            = q.rs1;
    assign exu.rs2_addr            = q.rs2;
    assign exu.rd_addr             = q.rd;
    assign exu.csr_addr            = q.csr;
    assign exu.imm                 = q.imm;
    assign exu.op                  = q.op;
    assign exu.mem_valid           = q.mem_valid;
    assign exu.mem_wen             = q.mem_wen;
    assign exu.mem_addr            = q.mem_addr;
    assign exu.mem_size            = q.mem_size;
    assign exu.mem_signed          = q.mem_signed;
    assign exu.mem_wmask           = q.wmask;
    assign exu.misalign            = q.misalign;
    assign exu.is_ebreak           = q.ebreak;
    assign exu.illegal_instruction = q.illegal;

`ifdef IDU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_inst_cnt    <= '0;
            perf_illegal_cnt <= '0;
        end else begin
            if (take && perf_inst_cnt != '1) perf_inst_cnt <= perf_inst_cnt + 1'b1;
            if (take && d.illegal && perf_illegal_cnt != '1) perf_illegal_cnt <= perf_illegal_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
- Registered, parametrised instruction decode stage for the NPC core. It sits between IFU and EXU/LSU.
- Decodes an RV32I subset, covering the full load/store width family and a 12-bit CSR address.
- Exposes a valid/ready handshake on both sides and supports flush.
- Holds a sticky HALT state after ebreak or an illegal instruction, so the downstream trap/halt logic sees exactly one terminating packet.

Parameters:
- XLEN, 32: data and address width. Legal values are 32 and 64. Immediates are sign-extended to XLEN.
- MASK_W, XLEN/8: memory byte-mask width.
- CNT_W, 32: width of the perf counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  stage can accept.
- inst  in  32  instruction word.
- pc  in  XLEN  PC of inst.
- rs1_raddr  out  5  combinational inst[19:15], used for the regfile read.
- rs1_data  in  XLEN  regfile data for rs1_raddr, valid in the same cycle.
- flush  in  1  discard the held packet and any same-cycle input.
- out_valid  out  1  decoded packet valid.
- out_ready  in  1  EXU accepts the packet.
- out_pc  out  XLEN  registered pc.
- wen  out  1  rd write enable.
- rs1_addr / rs2_addr / rd_addr  out  5 each  register addresses.
- csr_addr  out  12  inst[31:20].
- imm  out  XLEN  decoded immediate.
- op  out  5  operation code: 0 ADD, 1 ADDI, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 LOAD, 7 STORE, 8 CSRRW, 9 EBREAK, 31 ILLEGAL.
- mem_valid  out  1  memory access present.
- mem_wen  out  1  1 = store.
- mem_addr  out  XLEN  rs1_data + imm, truncated to XLEN.
- mem_size  out  2  0 byte, 1 half, 2 word.
- mem_signed  out  1  sign-extend the load result.
- mem_wmask  out  MASK_W  store byte enables.
- misalign  out  1  misaligned half or word access.
- is_ebreak  out  1  halt request.
- illegal_instruction  out  1  decode failure.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs are 0.
  - State is RUN.
  - in_ready is 1 after release.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready && !flush.
  - On accept: all outputs are registered from the combinational decode of inst, pc and rs1_data, and out_valid becomes 1 on the next edge.
  - Latency is 1 cycle.
- Drain: out_valid && out_ready with no accept clears out_valid. Back-to-back accept and drain sustains one instruction per cycle.
- Stall: while out_valid && !out_ready, every output holds stable.
- Flush:
  - Takes priority over everything else; out_valid becomes 0 next cycle.
  - A same-cycle input is dropped.
  - State is unchanged.
- Zero instruction: inst==0 is accepted as a bubble and does not set out_valid (treated as a drain).
- Decode:
  - Immediates use I/S/U/J formats, sign-extended to XLEN.
  - LOAD funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. mem_signed=1 for lb, lh and lw.
  - STORE funct3: 000 sb, 001 sh, 010 sw.
  - Any other funct3 on the LOAD or STORE opcode decodes as ILLEGAL.
  - CSRRW: csr_addr=inst[31:20], rs1_addr=inst[19:15].
  - Unmatched nonzero inst: op=ILLEGAL, illegal_instruction=1, is_ebreak=1, wen=0, mem_valid=0.
- Store mask:
  - Byte: 1 << addr[k-1:0], where k=2 for XLEN=32 and k=3 for XLEN=64.
  - Half: 2'b11 << addr[k-1:0], with addr[0] forced to 0.
  - Word: 4'hF << addr[k-1:0], with addr[1:0] forced to 0.
  - Loads use mem_wmask=0.
- Misalign:
  - misalign=1 when a half access has addr[0]=1, or a word access has addr[1:0]!=0.
  - The packet is still emitted with mem_valid=1; EXU traps on it.
- Writes to rd=x0: wen=0 even for writing ops.
- State machine:
  - RUN to HALT on accepting an EBREAK or ILLEGAL packet.
  - HALT keeps in_ready=0 and lets the held packet drain normally.
  - HALT is left only by reset.
  - A flush in the same cycle as that accept prevents the transition.

Optional Feature:
- Macro: IDU_PERF_CNT_EN.
- When defined:
  - Adds output ports perf_inst_cnt and perf_illegal_cnt, each CNT_W bits wide.
  - perf_inst_cnt increments on every accept with nonzero inst.
  - perf_illegal_cnt increments on every accepted ILLEGAL.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: neither port nor the counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset release -> all outputs are 0 and in_ready=1.
- lw x5,8(x1) with rs1_data=0x1000 -> next cycle: out_valid=1, op=6, mem_addr=0x1008, mem_size=2, mem_signed=1, wen=1, rd_addr=5.
- sh x2,3(x1) with rs1_data=0x2000 -> mem_addr=0x2003, mem_wmask=4'b1100, misalign=1.
- sb at address 0x1001 -> mem_wmask=4'b0010, mem_wen=1.
- Hold out_ready=0 for 3 cycles while in_valid=1 -> outputs stable and in_ready=0. Then out_ready=1 -> the next instruction is accepted the same cycle.
- Issue inst=0xFFFFFFFF -> illegal_instruction=1, is_ebreak=1, in_ready=0 thereafter. A flush issued in the cycle the next instruction is offered -> no packet.
